// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial word shifter with optional inter-word gap
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    // Unreachable value when GAP is 0; the gap state is never entered then.
    localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [3:0]        gcnt, gcnt_d;
    logic [WIDTH-1:0]  sreg;
    logic              load, shift_en;
    logic              last_bit;
    logic              transfer;

    assign last_bit  = (state == ST_SHIFT) && (cnt == LAST_BIT);
    assign din_ready = rst_n && ((state == ST_IDLE) || (last_bit && (GAP == 0)));
    assign transfer  = din_valid && din_ready;

    // The current bit always sits at the outgoing end of the shift register.
    assign x_valid = (state == ST_SHIFT);
    assign x_out   = x_valid && ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
    assign busy    = (state != ST_IDLE);
    assign done    = last_bit;

    // State, bit counter and gap counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            gcnt  <= gcnt_d;
        end
    end

    // Next-state logic: load on transfer, shift through the word, then gap or idle.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        gcnt_d   = gcnt;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (transfer) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt == LAST_BIT) begin
                    cnt_d = '0;
                    if (GAP == 0) begin
                        if (transfer) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_GAP;
                        gcnt_d  = '0;
                    end
                end else begin
                    cnt_d    = cnt + 1'b1;
                    shift_en = 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gcnt_d  = '0;
            end
        endcase
    end

    // Word capture and shifting toward the outgoing end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift_en) begin
            sreg <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - randomized and directed checks of bit_serializer against a queue model
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din_a [3];
    logic       dv    [3];
    logic       rdy   [3];
    logic       xo    [3];
    logic       xv    [3];
    logic       bz    [3];
    logic       dn    [3];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din_a[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
        .x_out(xo[0]), .x_valid(xv[0]), .busy(bz[0]), .done(dn[0]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din_a[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
        .x_out(xo[1]), .x_valid(xv[1]), .busy(bz[1]), .done(dn[1]));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(3)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din_a[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
        .x_out(xo[2]), .x_valid(xv[2]), .busy(bz[2]), .done(dn[2]));

    int msbp [3] = '{1, 0, 1};
    int gapp [3] = '{0, 0, 3};

    // Model: per instance, the queue of future per-cycle outputs {busy, valid, bit, done}.
    logic [3:0] mq   [3][16];
    int         mlen [3];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic logic mrdy(input int i);
        return (mlen[i] == 0) || (gapp[i] == 0 && mlen[i] == 1);
    endfunction

    task automatic model_edge();
        logic r;
        for (int i = 0; i < 3; i++) begin
            r = mrdy(i);
            if (mlen[i] > 0) begin
                for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
                mlen[i]--;
            end
            if (dv[i] && r) begin
                for (int b = 0; b < 8; b++)
                    mq[i][mlen[i]+b] = {1'b1, 1'b1,
                                        (msbp[i] != 0) ? din_a[i][7-b] : din_a[i][b],
                                        (b == 7)};
                mlen[i] += 8;
                for (int g = 0; g < gapp[i]; g++) begin
                    mq[i][mlen[i]] = 4'b1000;
                    mlen[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] e;
        for (int i = 0; i < 3; i++) begin
            e = (mlen[i] > 0) ? mq[i][0] : 4'b0000;
            check("busy",      i, bz[i],  e[3]);
            check("x_valid",   i, xv[i],  e[2]);
            check("x_out",     i, xo[i],  e[1]);
            check("done",      i, dn[i],  e[0]);
            check("din_ready", i, rdy[i], mrdy(i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset pulse placed well away from any rising edge.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_x_out",     i, xo[i],  1'b0);
            check("rst_x_valid",   i, xv[i],  1'b0);
            check("rst_busy",      i, bz[i],  1'b0);
            check("rst_done",      i, dn[i],  1'b0);
            check("rst_din_ready", i, rdy[i], 1'b0);
            mlen[i] = 0;
        end
        #1 rst_n = 1'b1;
    endtask

    logic [7:0]  seq0, seq1;
    logic [15:0] seq16;
    logic [19:0] vpat, rpat;
    int          nv, nd, dpos;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dv[i]    = 1'b0;
            din_a[i] = 8'h00;
            mlen[i]  = 0;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            check("init_din_ready", i, rdy[i], 1'b0);
            check("init_x_valid",   i, xv[i],  1'b0);
            check("init_busy",      i, bz[i],  1'b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 compare_all();
        @(negedge clk);

        // Single word on u0 (A0, MSB first) and u1 (05, LSB first); din churns and
        // a request lands mid-word, neither may disturb the bits.
        din_a[0] = 8'hA0; dv[0] = 1'b1;
        din_a[1] = 8'h05; dv[1] = 1'b1;
        dpos = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            seq0[7-k] = xo[0];
            seq1[7-k] = xo[1];
            if (dn[0]) dpos = k;
            dv[0] = (k == 2); din_a[0] = 8'($urandom);
            dv[1] = 1'b0;     din_a[1] = 8'($urandom);
        end
        dv[0] = 1'b0;
        check("seq_msb_A0", 0, seq0, 8'hA0);
        check("seq_lsb_05", 1, seq1, 8'hA0);
        check("done_pos",   0, dpos, 7);
        step();
        check("idle_ready", 0, rdy[0], 1'b1);
        check("idle_busy",  0, bz[0],  1'b0);

        // Back-to-back FF then 00 with din_valid held high.
        din_a[0] = 8'hFF; dv[0] = 1'b1;
        nv = 0; nd = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            seq16[15-k] = xo[0];
            nv += int'(xv[0]);
            nd += int'(dn[0]);
            din_a[0] = 8'h00;
            if (k == 8) dv[0] = 1'b0;
        end
        check("b2b_bits",  0, seq16, 16'hFF00);
        check("b2b_valid", 0, nv, 16);
        check("b2b_done",  0, nd, 2);
        step();

        // Two requests through the GAP=3 instance.
        din_a[2] = 8'hA5; dv[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            vpat[19-k] = xv[2];
            rpat[19-k] = rdy[2];
            if (k == 12) dv[2] = 1'b0;
        end
        check("gap_valid_pat", 2, vpat, 20'hFF0FF);
        check("gap_ready_pat", 2, rpat, 20'h00100);
        repeat (4) step();

        // Reset in the middle of a word, then a fresh word starts from its first bit.
        din_a[0] = 8'h3C; dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        repeat (3) step();
        reset_pulse();
        din_a[0] = 8'hC3; dv[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            seq0[7-k] = xo[0];
            dv[0] = 1'b0;
        end
        check("post_reset_word", 0, seq0, 8'hC3);
        step();

        // Randomized traffic on all three instances with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                dv[i]    = ($urandom_range(9) < 6);
                din_a[i] = 8'($urandom);
            end
            if ($urandom_range(199) == 0) reset_pulse();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
